// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multi-digit 7-segment scan controller with frame-synchronous double buffer
//
// Purpose:
//   Accepts a packed word of 4-bit digit codes over a valid/ready handshake.
//   The word is held in a shadow buffer and moved to the display buffer only at a
//   frame boundary. The boundary is the edge that leaves the ON window of the last
//   digit and enters the BLANK window of digit 0. This keeps a partially scanned
//   frame from mixing two words.
//   Each digit slot is REFRESH_DIV cycles long. The first BLANK_CYC cycles keep
//   every enable low while the new code settles in the downstream decoder. The
//   remaining cycles assert the one-hot enable for that digit.
//
// Optional feature:
//   SEG_SCAN_LZB_EN - leading-zero blanking. When this macro is defined, a digit
//   k > 0 keeps its enable low if it and every digit above it are zero. Digit 0 is
//   always shown. The code output and the slot timing do not change.
//
// Parameters:
//   DIGITS      - digits scanned (2..8)
//   REFRESH_DIV - cycles per digit slot, blank plus on
//   BLANK_CYC   - blank cycles at the start of each slot (1 <= BLANK_CYC < REFRESH_DIV)
//
// Ports:
//   i_clk          in   1          rising-edge clock
//   i_rst_n        in   1          asynchronous active-low reset
//   i_in_valid     in   1          i_digits_in holds a new display word
//   o_in_ready     out  1          a word can be accepted (no word pending)
//   i_digits_in    in   4*DIGITS   packed codes; [3:0] is digit 0 (rightmost)
//   o_code         out  4          code of the current slot, to the decoder
//   o_an           out  DIGITS     one-hot digit enable, active-high; zero while blanking
//   o_frame_tick   out  1          one-cycle pulse in the first cycle of each digit-0 slot
//                                  (not asserted for the first frame after reset)

module seg_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [4*DIGITS-1:0]   i_digits_in,
  output logic [3:0]            o_code,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = 4 * DIGITS;

  localparam logic [IW-1:0] LP_IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] LP_CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] LP_BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Scan state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [CW-1:0]     r_slot_cnt;
  logic [CW-1:0]     w_cnt_nxt;

  // Double buffer
  logic [DW-1:0]     r_shadow;
  logic [DW-1:0]     w_shadow_nxt;
  logic [DW-1:0]     r_disp;
  logic [DW-1:0]     w_disp_nxt;
  logic              r_pending;
  logic              w_pending_nxt;

  // Registered outputs and their next values
  logic [3:0]        r_code;
  logic [3:0]        w_code_nxt;
  logic [DIGITS-1:0] r_an;
  logic [DIGITS-1:0] w_an_nxt;
  logic              r_frame_tick;
  logic [DIGITS-1:0] w_digit_en;

  logic              w_accept;
  logic              w_slot_end;
  logic              w_frame_end;

  // ---------------------------------------------------------------------------
  // Handshake and slot/frame boundaries
  // ---------------------------------------------------------------------------
  assign w_accept    = i_in_valid && !r_pending;
  assign w_slot_end  = (r_slot_cnt == LP_CNT_LAST);
  assign w_frame_end = (r_state == ST_ON) && w_slot_end && (r_idx == LP_IDX_LAST);

  // ---------------------------------------------------------------------------
  // FSM next-state: BLANK covers counts 0..BLANK_CYC-1, ON covers the rest.
  // The digit index advances on the same edge that re-enters BLANK.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = w_slot_end ? '0 : r_slot_cnt + 1'b1;
    case (r_state)
      ST_BLANK: begin
        if (r_slot_cnt == LP_BLANK_LAST) begin
          w_state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (w_slot_end) begin
          w_state_nxt = ST_BLANK;
          w_idx_nxt   = (r_idx == LP_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double buffer. Commit only releases a word that was pending before this edge,
  // so a word accepted on the boundary edge waits for the following frame.
  // Accept is impossible while pending, so accept and commit never collide.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_disp_nxt    = r_disp;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    if (w_frame_end && r_pending) begin
      w_disp_nxt    = r_shadow;
      w_pending_nxt = 1'b0;
    end
    if (w_accept) begin
      w_shadow_nxt  = i_digits_in;
      w_pending_nxt = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit enable mask
  // ---------------------------------------------------------------------------
`ifdef SEG_SCAN_LZB_EN
  // A digit is a leading zero when it and every digit above it are zero.
  // The mask is built from the next display word so that it lines up with
  // o_an, which is registered.
  always_comb begin
    w_digit_en = '1;
    for (int k = 1; k < DIGITS; k++) begin
      if ((w_disp_nxt >> (4 * k)) == '0) begin
        w_digit_en[k] = 1'b0;
      end
    end
  end
`else
  assign w_digit_en = '1;
`endif

  // ---------------------------------------------------------------------------
  // Output next values. The outputs are computed from next-state values so that
  // the registered outputs line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_code_nxt = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_an_nxt   = '0;
    if (w_state_nxt == ST_ON) begin
      w_an_nxt = w_digit_en & (DIGITS'(1) << w_idx_nxt);
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_BLANK;
      r_idx      <= '0;
      r_slot_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_slot_cnt <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow     <= '0;
      r_disp       <= '0;
      r_pending    <= 1'b0;
      r_code       <= '0;
      r_an         <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_shadow     <= w_shadow_nxt;
      r_disp       <= w_disp_nxt;
      r_pending    <= w_pending_nxt;
      r_code       <= w_code_nxt;
      r_an         <= w_an_nxt;
      // The reset entry into digit 0 is not an edge-driven boundary, so the
      // first frame after reset never pulses.
      r_frame_tick <= w_frame_end;
    end
  end

  assign o_in_ready   = !r_pending;
  assign o_code       = r_code;
  assign o_an         = r_an;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux (DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2)

module tb_seg_scan_mux;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 8;
  localparam int BLANK_CYC   = 2;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] digits_in = '0;
  logic        in_ready;
  logic [3:0]  code;
  logic [3:0]  an;
  logic        frame_tick;

  seg_scan_mux #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_digits_in  (digits_in),
    .o_code       (code),
    .o_an         (an),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] an;
    logic       ft;
    logic       rdy;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_push = 0;
  int          n_pop  = 0;
  bit          mon_en = 1'b0;

  // Reference model state: cycle number since reset release, word on display,
  // buffered word and its pending flag.
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s t=%0d got %0h want %0h", nm, t, act, want);
    end
  endtask

  // Expected outputs in cycle tt for a display word d.
  function automatic exp_t model_out(input int tt, input logic [15:0] d, input bit pend);
    exp_t e;
    int   pos;
    int   dig;
    bit   vis;
    pos    = tt % REFRESH_DIV;
    dig    = (tt / REFRESH_DIV) % DIGITS;
    e.code = 4'((d >> (4 * dig)) & 16'h000F);
    e.an   = 4'h0;
    vis    = 1'b1;
`ifdef SEG_SCAN_LZB_EN
    if (dig > 0 && (d >> (4 * dig)) == 16'h0000) vis = 1'b0;
`endif
    if (pos >= BLANK_CYC && vis) e.an = 4'(1 << dig);
    e.ft   = (pos == 0 && dig == 0 && tt > 0);
    e.rdy  = !pend;
    return e;
  endfunction

  // Apply the effect of the clock edge that ends cycle t.
  task automatic model_edge(input bit v, input logic [15:0] din);
    bit was_pend;
    was_pend = m_pend;
    if (((t + 1) % FRAME) == 0 && was_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (v && !was_pend) begin
      m_shadow = din;
      m_pend   = 1'b1;
    end
    t++;
  endtask

  // One cycle: queue the expectation, drive inputs, advance through the edge.
  task automatic step(input bit v, input logic [15:0] din);
    exp_q.push_back(model_out(t, m_disp, m_pend));
    n_push++;
    in_valid  = v;
    digits_in = din;
    @(posedge clk);
    model_edge(v, din);
    #1;
  endtask

  task automatic model_reset();
    t        = 0;
    m_disp   = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  // Monitor: pops one expectation per cycle and compares away from the edge.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_pop++;
      chk("code",       32'(code),       32'(e.code));
      chk("an",         32'(an),         32'(e.an));
      chk("frame_tick", 32'(frame_tick), 32'(e.ft));
      chk("in_ready",   32'(in_ready),   32'(e.rdy));
      chk("an_onehot",  32'($countones(an) <= 1), 32'd1);
    end
  end

  initial begin
    logic [15:0] w;
    bit          found;

    // Reset values while rst_n is held low
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an",       32'(an),         32'd0);
    chk("rst_code",     32'(code),       32'd0);
    chk("rst_in_ready", 32'(in_ready),   32'd1);
    chk("rst_ft",       32'(frame_tick), 32'd0);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Load 0x1234 in the first cycle, then hold 0xABCD against back-pressure
    step(1'b1, 16'h1234);
    for (int i = 1; i <= 40; i++) step(1'b1, 16'hABCD);
    for (int i = 41; i < 100; i++) step(1'b0, 16'($urandom));

    // Leading-zero pattern
    step(1'b1, 16'h0050);
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 16'h0000);

    // Randomized traffic with frequent leading zeros
    for (int i = 0; i < 600; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0: w = w & 16'h00FF;
        1: w = w & 16'h0F0F;
        2: w = w & 16'h000F;
        default: ;
      endcase
      step($urandom_range(0, 9) == 0, w);
    end

    // Reset in the digit-2 ON window with a word pending
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_pend && ((t / REFRESH_DIV) % DIGITS) == 2 && (t % REFRESH_DIV) == 4) begin
        found = 1'b1;
      end else begin
        step(!m_pend, 16'h9876);
      end
    end
    chk("reset_window_found", 32'(found), 32'd1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_an",       32'(an),         32'd0);
    chk("midrst_in_ready", 32'(in_ready),   32'd1);
    chk("midrst_code",     32'(code),       32'd0);
    chk("midrst_ft",       32'(frame_tick), 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    model_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 16'h0000);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("push_pop",      32'(n_pop),        32'(n_push));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Multi-digit scan controller for the 7-segment display path. It accepts a packed word of 4-bit digit codes through a valid/ready handshake. It double-buffers the word so that updates apply only at frame boundaries, then time-multiplexes the digits one at a time. Each slot drives the digit's code into the downstream binary-to-7-segment decoder and asserts the matching one-hot digit enable, with a blanking gap between slots to prevent ghosting.

## Interface
- DIGITS, 4: number of digits scanned; legal range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot (blank plus on).
- BLANK_CYC, 16: cycles per slot with all enables low; 1 <= BLANK_CYC < REFRESH_DIV.

Ports:
- clk  in  1  the one clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  digits_in holds a new display word.
- in_ready  out  1  block can accept a word; equal to !pending.
- digits_in  in  4*DIGITS  packed codes; [3:0] is digit 0 (least significant, rightmost).
- code  out  4  code for the current slot; feeds the decoder's 4-bit input.
- an  out  DIGITS  one-hot digit enable, active-high; all zero while blanking.
- frame_tick  out  1  one-cycle pulse in the first cycle of each digit-0 slot.

## Operation
- Registers:
  - shadow (4*DIGITS) and pending flag hold an accepted word that is not yet shown.
  - disp (4*DIGITS) holds the word on display.
  - idx is the digit index; slot_cnt is the cycle counter within a slot; the state is BLANK or ON.
- Accept: on a rising edge with in_valid && in_ready, shadow <= digits_in and pending <= 1. No accept is possible while pending = 1.
- Commit: on the edge that moves from ON of digit DIGITS-1 to BLANK of digit 0, if pending = 1 then disp <= shadow and pending <= 0.
  - A word accepted on that same edge goes into shadow and is committed at the next frame boundary.
- FSM, per slot:
  - BLANK: an = 0 for BLANK_CYC cycles. code is already loaded with disp[idx], so the decoder output settles before the enable.
  - ON: an = 1 << idx for REFRESH_DIV - BLANK_CYC cycles.
  - After ON: idx <= (idx == DIGITS-1) ? 0 : idx+1, and the state returns to BLANK.
- slot_cnt counts 0..REFRESH_DIV-1 and wraps to 0 at the slot end. BLANK covers counts 0..BLANK_CYC-1; ON covers the rest.
- An idx change and the code update happen on the same edge as the BLANK entry.
- an never has more than one bit set. It is never nonzero in a BLANK cycle.
- Reset values: an = 0, code = 0, frame_tick = 0, in_ready = 1, pending = 0, shadow = 0, disp = 0, idx = 0, slot_cnt = 0, state = BLANK.
  - Reset takes effect immediately, mid-slot or mid-handshake. A pending word is discarded.

## Timing
- All outputs are registered; none has a combinational path from the inputs.
- Frame length is DIGITS*REFRESH_DIV cycles. The first slot after reset release is digit 0 BLANK, starting at slot_cnt 0.
- frame_tick pulses on every digit-0 BLANK entry after the first. It is not asserted in the first frame after reset.
- Accept-to-display latency: from the accepting edge to the next frame boundary, between 1 and DIGITS*REFRESH_DIV cycles.
- in_ready falls the cycle after the accept. It rises the cycle after the commit.
- Latency from code to decoder segments is 0 cycles downstream (the decoder is combinational). The enable lags code by BLANK_CYC cycles.

## Configuration
- SEG_SCAN_LZB_EN (leading-zero blanking):
  - Defined: during ON, an stays 0 for any digit k > 0 whose code is 0 when every digit above k is also 0. code still cycles normally, and slot timing is unchanged. Digit 0 is never suppressed.
  - Undefined: every digit is enabled in its ON window regardless of value.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
- Reset: with rst_n low, an = 0, code = 0, in_ready = 1, frame_tick = 0. All four slots then scan a display of 0000.
- Load 0x1234 in the first cycle after reset: in_ready = 0 from the next cycle. Commit happens at cycle 32 and frame_tick is high in that cycle. The following slots show code 4 with an = 0001, code 3 with an = 0010, code 2 with an = 0100, code 1 with an = 1000.
- Back-to-back loads: present 0xABCD while 0x1234 is pending. It is held off (in_ready = 0) until the cycle after the commit, is accepted then, and is displayed one frame later.
- Blank/overlap check: across 3 frames, each slot has exactly 2 cycles with an = 0 followed by 6 cycles one-hot. popcount(an) <= 1 at all times.
- Reset mid-operation: drop rst_n during the digit-2 ON window with a word pending. an = 0 immediately, in_ready = 1, and disp = 0 after release.
- SEG_SCAN_LZB_EN defined, load 0x0050: an[3] and an[2] are never asserted; digit 1 shows code 5 and digit 0 shows code 0. Without the macro, all four digits are enabled.
